// File: rtl/reg_wrchan_arb.sv
// N-to-1 register write-channel concentrator: per-channel FIFOs drained round-robin
// onto one slave write port, with optional same-address write combining.
module reg_wrchan_arb #(
  parameter int K_DWIDTH = 8,
  parameter int K_AWIDTH = 16,
  parameter int K_NCHAN  = 2,
  parameter int K_DEPTH  = 4,
  parameter int K_MERGE  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [K_NCHAN*K_AWIDTH-1:0]   i_addr,
  input  logic [K_NCHAN*K_DWIDTH-1:0]   i_data,
  input  logic [K_NCHAN*K_DWIDTH-1:0]   i_bmask,
  input  logic [K_NCHAN-1:0]            i_write,
  input  logic [K_NCHAN-1:0]            i_ovf_clr,
  output logic [K_AWIDTH-1:0]           o_addr,
  output logic [K_DWIDTH-1:0]           o_data,
  output logic [K_DWIDTH-1:0]           o_bmask,
  output logic                          o_write,
  output logic [K_NCHAN-1:0]            o_full,
  output logic [K_NCHAN-1:0]            o_overflow
);

  localparam int PW   = $clog2(K_DEPTH);
  localparam int CNTW = $clog2(K_DEPTH + 1);
  localparam int CW   = (K_NCHAN > 1) ? $clog2(K_NCHAN) : 1;
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(K_DEPTH);
  localparam logic [CW-1:0]   RR_RST   = CW'(K_NCHAN - 1);

  logic [K_NCHAN-1:0]  nonempty;
  logic [K_NCHAN-1:0]  pop;
  logic [K_AWIDTH-1:0] head_addr  [K_NCHAN];
  logic [K_DWIDTH-1:0] head_data  [K_NCHAN];
  logic [K_DWIDTH-1:0] head_bmask [K_NCHAN];

  logic [CW-1:0]       rr_q, rr_d;
  logic                gnt_vld;
  logic [CW-1:0]       gnt_idx;
  logic [CW-1:0]       scan_idx;

  logic                write_q;
  logic [K_AWIDTH-1:0] addr_q, addr_d;
  logic [K_DWIDTH-1:0] data_q, data_d;
  logic [K_DWIDTH-1:0] bmask_q, bmask_d;

  // Scan from farthest to nearest so the channel closest after the pointer wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = rr_q;
    scan_idx = rr_q;
    for (int off = K_NCHAN; off >= 1; off--) begin
      scan_idx = CW'((int'(rr_q) + off) % K_NCHAN);
      if (nonempty[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d    = rr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bmask_d = bmask_q;
    if (gnt_vld) begin
      rr_d    = gnt_idx;
      addr_d  = head_addr[gnt_idx];
      data_d  = head_data[gnt_idx];
      bmask_d = head_bmask[gnt_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q    <= RR_RST;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      bmask_q <= '0;
    end else begin
      rr_q    <= rr_d;
      write_q <= gnt_vld;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bmask_q <= bmask_d;
    end
  end

  assign o_write = write_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_bmask = bmask_q;

  for (genvar c = 0; c < K_NCHAN; c++) begin : g_chan
    logic [K_AWIDTH-1:0] mem_addr  [K_DEPTH];
    logic [K_DWIDTH-1:0] mem_data  [K_DEPTH];
    logic [K_DWIDTH-1:0] mem_bmask [K_DEPTH];

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [PW-1:0]       tail_last;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic [K_AWIDTH-1:0] in_addr;
    logic [K_DWIDTH-1:0] in_data;
    logic [K_DWIDTH-1:0] in_bmask;
    logic                merge, push, drop;

    assign in_addr   = i_addr [c*K_AWIDTH +: K_AWIDTH];
    assign in_data   = i_data [c*K_DWIDTH +: K_DWIDTH];
    assign in_bmask  = i_bmask[c*K_DWIDTH +: K_DWIDTH];
    assign tail_last = tail_q - PW'(1);

    assign nonempty[c]   = (cnt_q != '0);
    assign head_addr[c]  = mem_addr[head_q];
    assign head_data[c]  = mem_data[head_q];
    assign head_bmask[c] = mem_bmask[head_q];

    // A lone entry that is leaving this cycle cannot absorb a merge.
    always_comb begin
      merge  = (K_MERGE != 0) && i_write[c] && nonempty[c] &&
               (mem_addr[tail_last] == in_addr) &&
               !(pop[c] && (cnt_q == CNTW'(1)));
      push   = i_write[c] && !merge && ((cnt_q != CNT_FULL) || pop[c]);
      drop   = i_write[c] && !merge && !push;
      head_d = pop[c] ? head_q + PW'(1) : head_q;
      tail_d = push   ? tail_q + PW'(1) : tail_q;
      cnt_d  = cnt_q;
      if (push && !pop[c])      cnt_d = cnt_q + CNTW'(1);
      else if (!push && pop[c]) cnt_d = cnt_q - CNTW'(1);
      full_d = (cnt_d == CNT_FULL);
      ovf_d  = drop | (ovf_q & ~i_ovf_clr[c]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
        full_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        cnt_q  <= cnt_d;
        full_q <= full_d;
        ovf_q  <= ovf_d;
      end
    end

    always_ff @(posedge i_clk) begin
      if (push) begin
        mem_addr[tail_q]  <= in_addr;
        mem_data[tail_q]  <= in_data;
        mem_bmask[tail_q] <= in_bmask;
      end else if (merge) begin
        mem_data[tail_last]  <= (mem_data[tail_last] & ~in_bmask) | (in_data & in_bmask);
        mem_bmask[tail_last] <= mem_bmask[tail_last] | in_bmask;
      end
    end

    assign o_full[c]     = full_q;
    assign o_overflow[c] = ovf_q;
  end

endmodule

// File: doc/reg_wrchan_arb.md
# reg_wrchan_arb

Parametrised N-to-1 register write-channel concentrator. Each of K_NCHAN master write channels (addr/data/bmask/write pulse) is buffered in its own K_DEPTH-entry FIFO. The block drains the FIFOs round-robin onto one slave write channel at up to one write per cycle. It sits between several register-bank masters (CPU bridge, debug port, DMA) and a single register bank, with optional same-address write combining and per-channel overflow reporting.

## Interface
- K_DWIDTH, 8, register data width
- K_AWIDTH, 16, register address width
- K_NCHAN, 2, number of master channels (1..16)
- K_DEPTH, 4, FIFO entries per channel (power of two, >=2)
- K_MERGE, 1, 1 = same-address write combining enabled, 0 = disabled

Ports. Channel c of each packed bus occupies [c*W +: W].
- i_clk  in  1  clock, all logic rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_addr  in  K_NCHAN*K_AWIDTH  master write addresses
- i_data  in  K_NCHAN*K_DWIDTH  master write data
- i_bmask  in  K_NCHAN*K_DWIDTH  master write bit masks
- i_write  in  K_NCHAN  master write pulses, one write per high cycle
- i_ovf_clr  in  K_NCHAN  clear sticky overflow flag
- o_addr  out  K_AWIDTH  slave write address
- o_data  out  K_DWIDTH  slave write data
- o_bmask  out  K_DWIDTH  slave write bit mask
- o_write  out  1  slave write pulse
- o_full  out  K_NCHAN  channel FIFO holds K_DEPTH entries
- o_overflow  out  K_NCHAN  sticky: a write on that channel was dropped

## Operation
- Reset (async assert, sync release): every output is 0. All FIFOs are empty. The round-robin pointer is K_NCHAN-1, so channel 0 wins first.
- Enqueue: i_write[c]=1 at a rising edge captures {addr,data,bmask} into the tail of FIFO c. The slave has no backpressure, so masters must observe o_full.
- Merge (K_MERGE=1): an incoming write merges into the tail entry instead of allocating a new one when all of the following hold:
  - FIFO c is non-empty;
  - the tail addr equals the incoming addr;
  - the tail entry is not being popped this cycle.
- Merge arithmetic: data = (tail.data & ~new.bmask) | (new.data & new.bmask); bmask = tail.bmask | new.bmask. A merge never changes the FIFO count.
- A write with bmask=0 is queued and forwarded normally.
- Full:
  - A write to a full FIFO is accepted if a merge applies, or if FIFO c is popped in the same cycle.
  - Otherwise the write is dropped and o_overflow[c] is set.
  - i_ovf_clr[c] clears o_overflow[c]. If a set and a clear occur in the same cycle, the set wins.
- Arbitration:
  - Each cycle, grant the first non-empty channel strictly after the pointer, searching cyclically.
  - The granted head is popped at the edge and loaded into the o_addr/o_data/o_bmask registers, with o_write=1 for one cycle.
  - The pointer updates to the granted channel.
  - If no channel is non-empty, o_write=0 and o_addr/o_data/o_bmask hold their last values.
- Simultaneous enqueue and pop on the same FIFO: the count is unchanged and the head and tail pointers each advance, wrapping modulo K_DEPTH.
- Arbitration and merge decisions use only registered FIFO state. There is no input-to-output combinational path.

## Timing
- Latency: a write sampled at edge k, into an empty FIFO with no contention, appears as o_write=1 in the cycle after edge k+1 (2 cycles).
- Throughput: one slave write per cycle aggregate. With all channels backlogged, each channel gets one write every K_NCHAN cycles.
- o_full[c] is registered and reflects the count after the edge. It asserts the cycle after the K_DEPTH-th entry is accepted.
- o_overflow[c] rises the cycle after the dropped write's edge.
- Asserting i_rst_n low mid-burst immediately forces o_write=0 and discards all FIFO contents.

## Test plan
- Single write, K_NCHAN=2: ch0 writes addr 0x0010, data 0xA5, bmask 0xFF at edge 0 -> o_write high one cycle after edge 1 with 0x0010/0xA5/0xFF; no further pulses.
- Round-robin: both FIFOs preloaded with 3 distinct writes each -> output order ch0,ch1,ch0,ch1,ch0,ch1 on 6 consecutive cycles; each channel's order is preserved.
- Merge: ch1 writes {0x0004, 0x0F, 0x0F} then {0x0004, 0xA0, 0xF0} while its entry is still queued -> a single output {0x0004, 0xAF, 0xFF}. With K_MERGE=0, two outputs are produced instead.
- Full/overflow, K_DEPTH=4: ch0 writes 5 distinct addresses while ch1 holds the grant -> o_full[0]=1 after the 4th; the 5th is dropped and o_overflow[0]=1. i_ovf_clr[0] clears it. A write on the cycle ch0 is popped while full is accepted.
- Wrap-around: 3*K_DEPTH writes streamed through ch0 with continuous draining -> all are emitted in order, none are lost, and o_full is never set.
- Reset mid-operation: i_rst_n pulled low with 2 entries queued -> o_write=0 asynchronously. After release there is no output, and ch0 is granted first.
